spi_slave_mode: RTL and testbench



---
 rtl/spi_slave_mode_if.sv | 47 ++++
 rtl/spi_slave_mode.sv | 206 ++++++++++++++++++++
 tb/tb_spi_slave_mode.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_mode_if.sv
// SPI slave bus bundle: external host pins plus the word-level TX/RX
// handshake towards the frame/command parser.
interface spi_slave_mode_if #(
    parameter int WORD_W = 8
);
    // Host-side SPI pins
    logic              spi_sclk_i;
    logic              spi_mosi_i;
    logic              spi_cs_n_i;
    logic              spi_miso_o;
    logic              spi_miso_oe_o;

    // Word-level side
    logic [WORD_W-1:0] spi_tx_data_i;
    logic              spi_tx_ack_o;
    logic              spi_rx_vld_o;
    logic [WORD_W-1:0] spi_rx_data_o;
    logic              spi_frame_err_o;

    // View of the SPI slave itself
    modport slave (
        input  spi_sclk_i,
        input  spi_mosi_i,
        input  spi_cs_n_i,
        input  spi_tx_data_i,
        output spi_miso_o,
        output spi_miso_oe_o,
        output spi_tx_ack_o,
        output spi_rx_vld_o,
        output spi_rx_data_o,
        output spi_frame_err_o
    );

    // View of whoever drives the pins and the TX word (host model + upstream)
    modport master (
        output spi_sclk_i,
        output spi_mosi_i,
        output spi_cs_n_i,
        output spi_tx_data_i,
        input  spi_miso_o,
        input  spi_miso_oe_o,
        input  spi_tx_ack_o,
        input  spi_rx_vld_o,
        input  spi_rx_data_o,
        input  spi_frame_err_o
    );
endinterface

// File: rtl/spi_slave_mode.sv
// Parametrised SPI slave: any CPOL/CPHA mode, WORD_W-bit words, MSB- or
// LSB-first. SCLK/MOSI/CS_N are oversampled in the clk_i domain through a
// 2-FF synchroniser plus one edge-detect stage. Received words are presented
// with a one-cycle valid strobe; TX words are fetched with a one-cycle ack.
// A chip-select release in the middle of a word raises a one-cycle error.
module spi_slave_mode #(
    parameter int WORD_W    = 8,
    parameter bit CPOL      = 1'b0,
    parameter bit CPHA      = 1'b0,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    spi_slave_mode_if.slave  bus
);

    localparam int                CNT_W    = (WORD_W > 2) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WORD_W - 1);

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers and edge detection
    // ------------------------------------------------------------------
    logic sclk_s1, sclk_s2, sclk_d;
    logic mosi_s1, mosi_s2;
    logic cs_s1,   cs_s2,   cs_d;
    logic sync_live;   // synchroniser first stage holds a real pin sample
    logic cs_armed;    // CS has been seen high since reset

    // Two-stage synchroniser plus edge-detect delay for every SPI pin.
    // NOTE: the synchroniser stages reset to the idle pin levels rather than
    // to zero, so leaving reset with an idle bus produces no phantom edges.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_s1   <= CPOL;
            sclk_s2   <= CPOL;
            sclk_d    <= CPOL;
            mosi_s1   <= 1'b0;
            mosi_s2   <= 1'b0;
            cs_s1     <= 1'b1;
            cs_s2     <= 1'b1;
            cs_d      <= 1'b1;
            sync_live <= 1'b0;
            cs_armed  <= 1'b0;
        end else begin
            sclk_s1   <= bus.spi_sclk_i;
            sclk_s2   <= sclk_s1;
            sclk_d    <= sclk_s2;
            mosi_s1   <= bus.spi_mosi_i;
            mosi_s2   <= mosi_s1;
            cs_s1     <= bus.spi_cs_n_i;
            cs_s2     <= cs_s1;
            cs_d      <= cs_s2;
            sync_live <= 1'b1;
            // A reset taken mid-frame must not turn the still-low CS into a
            // fresh frame start: only a real high CS sample arms the slave.
            if (sync_live && cs_s1) begin
                cs_armed <= 1'b1;
            end
        end
    end

    logic lead_edge, trail_edge, sample_edge, drive_edge;
    logic cs_fall, cs_rise;

    assign lead_edge   = (sclk_d == CPOL) && (sclk_s2 != CPOL);
    assign trail_edge  = (sclk_d != CPOL) && (sclk_s2 == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign drive_edge  = CPHA ? lead_edge  : trail_edge;
    assign cs_fall     = cs_armed && cs_d && !cs_s2;
    assign cs_rise     = !cs_d && cs_s2;

    // ------------------------------------------------------------------
    // Bit-order helpers
    // ------------------------------------------------------------------
    function automatic logic first_bit(input logic [WORD_W-1:0] w);
        return MSB_FIRST ? w[WORD_W-1] : w[0];
    endfunction

    function automatic logic [WORD_W-1:0] shift_out(input logic [WORD_W-1:0] w);
        return MSB_FIRST ? {w[WORD_W-2:0], 1'b0} : {1'b0, w[WORD_W-1:1]};
    endfunction

    // ------------------------------------------------------------------
    // Frame FSM, shift registers and registered outputs
    // ------------------------------------------------------------------
    state_t             state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [WORD_W-1:0]  rx_shift;
    logic [WORD_W-1:0]  rx_next;
    logic [WORD_W-1:0]  tx_shift;   // bits still to be driven after miso_q
    logic [WORD_W-1:0]  rx_data_q;
    logic               rx_vld_q;
    logic               tx_ack_q;
    logic               frame_err_q;
    logic               miso_q;
    logic               miso_oe_q;

    // Receive shift register with the currently synchronised MOSI bit merged in.
    always_comb begin
        rx_next = MSB_FIRST ? {rx_shift[WORD_W-2:0], mosi_s2}
                            : {mosi_s2, rx_shift[WORD_W-1:1]};
    end

    // Frame sequencing: CS tracking, bit counting, RX assembly, TX fetch/shift.
    // NOTE: every register here uses non-blocking assignment so all updates in
    // one clock see the same pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            rx_data_q   <= '0;
            rx_vld_q    <= 1'b0;
            tx_ack_q    <= 1'b0;
            frame_err_q <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
        end else begin
            // Strobes default low and are raised for exactly one cycle below.
            rx_vld_q    <= 1'b0;
            tx_ack_q    <= 1'b0;
            frame_err_q <= 1'b0;

            case (state)
                ST_IDLE: begin
                    miso_q    <= 1'b0;
                    miso_oe_q <= 1'b0;
                    if (cs_fall) begin
                        state     <= ST_ACTIVE;
                        bit_cnt   <= '0;
                        miso_oe_q <= 1'b1;
                        tx_ack_q  <= 1'b1;
                        if (CPHA) begin
                            // First bit appears on the first leading edge.
                            tx_shift <= bus.spi_tx_data_i;
                            miso_q   <= 1'b0;
                        end else begin
                            // First bit must already be on MISO for the first sample.
                            tx_shift <= shift_out(bus.spi_tx_data_i);
                            miso_q   <= first_bit(bus.spi_tx_data_i);
                        end
                    end
                end

                ST_ACTIVE: begin
                    if (cs_rise) begin
                        // CS release takes priority over any coincident SCLK edge.
                        state     <= ST_IDLE;
                        bit_cnt   <= '0;
                        miso_q    <= 1'b0;
                        miso_oe_q <= 1'b0;
                        if (bit_cnt != '0) begin
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        if (sample_edge) begin
                            rx_shift <= rx_next;
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt   <= '0;
                                rx_data_q <= rx_next;
                                rx_vld_q  <= 1'b1;
                                if (CPHA) begin
                                    // Next word is fetched ahead of its first leading edge.
                                    tx_shift <= bus.spi_tx_data_i;
                                    tx_ack_q <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end

                        if (drive_edge) begin
                            if (!CPHA && (bit_cnt == '0)) begin
                                // Trailing edge right after a completed word: start the next one.
                                tx_shift <= shift_out(bus.spi_tx_data_i);
                                miso_q   <= first_bit(bus.spi_tx_data_i);
                                tx_ack_q <= 1'b1;
                            end else begin
                                tx_shift <= shift_out(tx_shift);
                                miso_q   <= first_bit(tx_shift);
                            end
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.spi_miso_o      = miso_q;
    assign bus.spi_miso_oe_o   = miso_oe_q;
    assign bus.spi_tx_ack_o    = tx_ack_q;
    assign bus.spi_rx_vld_o    = rx_vld_q;
    assign bus.spi_rx_data_o   = rx_data_q;
    assign bus.spi_frame_err_o = frame_err_q;

endmodule

// File: tb/tb_spi_slave_mode.sv
// Bench for spi_slave_mode: four instances covering mode 0 / W8 / MSB-first,
// mode 3, LSB-first W16 and mode 1. A host model bit-bangs the pins; received
// words go through a scoreboard queue per instance, MISO words and strobe
// counts are compared against a vector table and a few hand-written sequences.
module tb_spi_slave_mode;

    localparam int H = 6;   // clk cycles per SCLK half period

    localparam int CFG_W    [4] = '{8, 8, 16, 8};
    localparam bit CFG_CPOL [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    localparam bit CFG_CPHA [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    localparam bit CFG_MSB  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Host pin drivers and upstream TX source per instance
    logic        sclk [4];
    logic        mosi [4];
    logic        cs_n [4];
    int          seed [4] = '{default: 0};

    // Strobe/level counters owned by the monitor
    int ack_cnt  [4] = '{default: 0};
    int err_cnt  [4] = '{default: 0};
    int vld_cnt  [4] = '{default: 0};
    int oe_cnt   [4] = '{default: 0};
    int miso_cnt [4] = '{default: 0};

    int checks = 0;
    int errors = 0;

    spi_slave_mode_if #(.WORD_W(8))  b0 ();
    spi_slave_mode_if #(.WORD_W(8))  b1 ();
    spi_slave_mode_if #(.WORD_W(16)) b2 ();
    spi_slave_mode_if #(.WORD_W(8))  b3 ();

    spi_slave_mode #(.WORD_W(8),  .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1))
        u_mode0 (.clk_i(clk), .rst_i(rst), .bus(b0));
    spi_slave_mode #(.WORD_W(8),  .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1))
        u_mode3 (.clk_i(clk), .rst_i(rst), .bus(b1));
    spi_slave_mode #(.WORD_W(16), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b0))
        u_lsb16 (.clk_i(clk), .rst_i(rst), .bus(b2));
    spi_slave_mode #(.WORD_W(8),  .CPOL(1'b0), .CPHA(1'b1), .MSB_FIRST(1'b1))
        u_mode1 (.clk_i(clk), .rst_i(rst), .bus(b3));

    assign b0.spi_sclk_i = sclk[0];
    assign b1.spi_sclk_i = sclk[1];
    assign b2.spi_sclk_i = sclk[2];
    assign b3.spi_sclk_i = sclk[3];
    assign b0.spi_mosi_i = mosi[0];
    assign b1.spi_mosi_i = mosi[1];
    assign b2.spi_mosi_i = mosi[2];
    assign b3.spi_mosi_i = mosi[3];
    assign b0.spi_cs_n_i = cs_n[0];
    assign b1.spi_cs_n_i = cs_n[1];
    assign b2.spi_cs_n_i = cs_n[2];
    assign b3.spi_cs_n_i = cs_n[3];
    // Upstream source advances by one on every ack
    assign b0.spi_tx_data_i = 8'(seed[0] + ack_cnt[0]);
    assign b1.spi_tx_data_i = 8'(seed[1] + ack_cnt[1]);
    assign b2.spi_tx_data_i = 16'(seed[2] + ack_cnt[2]);
    assign b3.spi_tx_data_i = 8'(seed[3] + ack_cnt[3]);

    logic        miso_w [4];
    logic        oe_w   [4];
    logic        ack_w  [4];
    logic        vld_w  [4];
    logic        err_w  [4];
    logic [31:0] rxd_w  [4];

    assign miso_w[0] = b0.spi_miso_o;      assign miso_w[1] = b1.spi_miso_o;
    assign miso_w[2] = b2.spi_miso_o;      assign miso_w[3] = b3.spi_miso_o;
    assign oe_w[0]   = b0.spi_miso_oe_o;   assign oe_w[1]   = b1.spi_miso_oe_o;
    assign oe_w[2]   = b2.spi_miso_oe_o;   assign oe_w[3]   = b3.spi_miso_oe_o;
    assign ack_w[0]  = b0.spi_tx_ack_o;    assign ack_w[1]  = b1.spi_tx_ack_o;
    assign ack_w[2]  = b2.spi_tx_ack_o;    assign ack_w[3]  = b3.spi_tx_ack_o;
    assign vld_w[0]  = b0.spi_rx_vld_o;    assign vld_w[1]  = b1.spi_rx_vld_o;
    assign vld_w[2]  = b2.spi_rx_vld_o;    assign vld_w[3]  = b3.spi_rx_vld_o;
    assign err_w[0]  = b0.spi_frame_err_o; assign err_w[1]  = b1.spi_frame_err_o;
    assign err_w[2]  = b2.spi_frame_err_o; assign err_w[3]  = b3.spi_frame_err_o;
    assign rxd_w[0]  = {24'h0, b0.spi_rx_data_o};
    assign rxd_w[1]  = {24'h0, b1.spi_rx_data_o};
    assign rxd_w[2]  = {16'h0, b2.spi_rx_data_o};
    assign rxd_w[3]  = {24'h0, b3.spi_rx_data_o};

    // Scoreboard queues of expected received words, one per instance
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] q2[$];
    logic [31:0] q3[$];

    // Host data for the current frame
    logic [31:0] mosi_words [5];
    logic [31:0] got_miso   [5];

    typedef struct {
        int              k;
        int              nwords;
        logic [4:0][31:0] words;
        logic [31:0]     seed;
        logic [4:0][31:0] exp_miso;
        int              exp_acks;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sb_push(input int k, input logic [31:0] w);
        case (k)
            0: q0.push_back(w);
            1: q1.push_back(w);
            2: q2.push_back(w);
            default: q3.push_back(w);
        endcase
    endtask

    function automatic int sb_size(input int k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    task automatic sb_pop_check(input int k);
        logic [31:0] e;
        bit          have;
        have = 1'b0;
        e    = '0;
        case (k)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            2: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
            default: if (q3.size() > 0) begin e = q3.pop_front(); have = 1'b1; end
        endcase
        if (have) check($sformatf("rx_word_dut%0d", k), rxd_w[k], e);
        else      check($sformatf("rx_vld_unexpected_dut%0d", k), {31'h0, vld_w[k]}, 32'h0);
    endtask

    // Monitor: count strobes and compare received words against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (ack_w[k])  ack_cnt[k]++;
                if (err_w[k])  err_cnt[k]++;
                if (oe_w[k])   oe_cnt[k]++;
                if (miso_w[k]) miso_cnt[k]++;
                if (vld_w[k]) begin
                    vld_cnt[k]++;
                    sb_pop_check(k);
                end
            end
        end
    end

    function automatic logic host_bit(input int k, input int n, input int nwords);
        int w;
        int j;
        int i;
        w = CFG_W[k];
        j = n / w;
        i = n % w;
        if (j >= nwords) return 1'b0;
        return CFG_MSB[k] ? mosi_words[j][w-1-i] : mosi_words[j][i];
    endfunction

    // Host model: one CS frame of up to nwords words, optionally cut short
    task automatic host_frame(input int k, input int nwords, input int max_bits, input bit release_cs);
        int   w, total, j, i;
        bit   cpol, cpha;
        logic got_bit;
        w    = CFG_W[k];
        cpol = CFG_CPOL[k];
        cpha = CFG_CPHA[k];
        total = nwords * w;
        if (max_bits < total) total = max_bits;
        for (int m = 0; m < 5; m++) got_miso[m] = '0;
        cs_n[k] = 1'b0;
        if (!cpha) mosi[k] = host_bit(k, 0, nwords);
        wait_clk(H);
        for (int n = 0; n < total; n++) begin
            j = n / w;
            i = n % w;
            if (i == w - 1) sb_push(k, mosi_words[j]);
            if (!cpha) begin
                got_bit = miso_w[k];
                sclk[k] = ~cpol;
                wait_clk(H);
                sclk[k] = cpol;
                mosi[k] = host_bit(k, n + 1, nwords);
                wait_clk(H);
            end else begin
                sclk[k] = ~cpol;
                mosi[k] = host_bit(k, n, nwords);
                wait_clk(H);
                got_bit = miso_w[k];
                sclk[k] = cpol;
                wait_clk(H);
            end
            if (CFG_MSB[k]) got_miso[j][w-1-i] = got_bit;
            else            got_miso[j][i]     = got_bit;
        end
        wait_clk(H);
        if (release_cs) begin
            cs_n[k] = 1'b1;
            mosi[k] = 1'b0;
            wait_clk(2 * H);
        end
    endtask

    initial begin
        int k, ack0, err0, vld0, oe0, miso0;

        for (int m = 0; m < 4; m++) begin
            sclk[m] = CFG_CPOL[m];
            mosi[m] = 1'b0;
            cs_n[m] = 1'b1;
        end

        vecs[0] = '{k: 0, nwords: 5,
                    words:    {32'h00, 32'h00, 32'h00, 32'h2B, 32'h2A},
                    seed:     32'h7E,
                    exp_miso: {32'h82, 32'h81, 32'h80, 32'h7F, 32'h7E},
                    exp_acks: 6};
        vecs[1] = '{k: 1, nwords: 1,
                    words:    {32'h0, 32'h0, 32'h0, 32'h0, 32'hA5},
                    seed:     32'h3C,
                    exp_miso: {32'h0, 32'h0, 32'h0, 32'h0, 32'h3C},
                    exp_acks: 2};
        vecs[2] = '{k: 2, nwords: 1,
                    words:    {32'h0, 32'h0, 32'h0, 32'h0, 32'h1234},
                    seed:     32'hBEEF,
                    exp_miso: {32'h0, 32'h0, 32'h0, 32'h0, 32'hBEEF},
                    exp_acks: 2};
        vecs[3] = '{k: 3, nwords: 1,
                    words:    {32'h0, 32'h0, 32'h0, 32'h0, 32'hC3},
                    seed:     32'h11,
                    exp_miso: {32'h0, 32'h0, 32'h0, 32'h0, 32'h11},
                    exp_acks: 2};

        // Reset state
        rst = 1'b1;
        wait_clk(3);
        for (int m = 0; m < 4; m++) begin
            check($sformatf("reset_ctrl_dut%0d", m),
                  {27'h0, miso_w[m], oe_w[m], ack_w[m], vld_w[m], err_w[m]}, 32'h0);
            check($sformatf("reset_rx_dut%0d", m), rxd_w[m], 32'h0);
        end
        rst = 1'b0;
        wait_clk(6);

        // Table-driven frames
        for (int v = 0; v < 4; v++) begin
            k = vecs[v].k;
            for (int j = 0; j < 5; j++) mosi_words[j] = vecs[v].words[j];
            seed[k] = int'(vecs[v].seed) - ack_cnt[k];
            ack0 = ack_cnt[k];
            err0 = err_cnt[k];
            host_frame(k, vecs[v].nwords, 1000, 1'b1);
            wait_clk(4);
            for (int j = 0; j < vecs[v].nwords; j++)
                check($sformatf("vec%0d_miso_word%0d", v, j), got_miso[j], vecs[v].exp_miso[j]);
            check($sformatf("vec%0d_acks", v), ack_cnt[k] - ack0, vecs[v].exp_acks);
            check($sformatf("vec%0d_frame_err", v), err_cnt[k] - err0, 0);
            check($sformatf("vec%0d_rx_all_seen", v), sb_size(k), 0);
            check($sformatf("vec%0d_oe_idle", v), {31'h0, oe_w[k]}, 32'h0);
        end

        // Mode 1: CS released after 5 bits
        ack0 = ack_cnt[3];
        err0 = err_cnt[3];
        vld0 = vld_cnt[3];
        mosi_words[0] = 32'h96;
        host_frame(3, 1, 5, 1'b1);
        wait_clk(4);
        check("abort_frame_err_pulses", err_cnt[3] - err0, 1);
        check("abort_no_rx_vld", vld_cnt[3] - vld0, 0);
        check("abort_rx_data_held", rxd_w[3], 32'hC3);
        check("abort_acks", ack_cnt[3] - ack0, 1);

        // Mode 0: reset after 3 bits with CS still low
        err0 = err_cnt[0];
        vld0 = vld_cnt[0];
        mosi_words[0] = 32'hF0;
        seed[0] = 32'h20 - ack_cnt[0];
        host_frame(0, 1, 3, 1'b0);
        check("pre_rst_oe_active", {31'h0, oe_w[0]}, 32'h1);
        rst = 1'b1;
        wait_clk(1);
        check("mid_rst_ctrl", {27'h0, miso_w[0], oe_w[0], ack_w[0], vld_w[0], err_w[0]}, 32'h0);
        check("mid_rst_rx", rxd_w[0], 32'h0);
        rst = 1'b0;
        wait_clk(12);
        check("post_rst_stays_idle", {31'h0, oe_w[0]}, 32'h0);
        cs_n[0] = 1'b1;
        wait_clk(2 * H);
        mosi_words[0] = 32'h55;
        seed[0] = 32'h33 - ack_cnt[0];
        host_frame(0, 1, 1000, 1'b1);
        wait_clk(4);
        check("post_rst_rx_data", rxd_w[0], 32'h55);
        check("post_rst_miso_word", got_miso[0], 32'h33);
        check("post_rst_rx_vld_count", vld_cnt[0] - vld0, 1);
        check("post_rst_no_frame_err", err_cnt[0] - err0, 0);
        check("post_rst_rx_all_seen", sb_size(0), 0);

        // SCLK toggling with CS high must be ignored
        ack0  = ack_cnt[0];
        vld0  = vld_cnt[0];
        oe0   = oe_cnt[0];
        miso0 = miso_cnt[0];
        for (int t = 0; t < 16; t++) begin
            sclk[0] = ~sclk[0];
            mosi[0] = 1'(($urandom));
            wait_clk(H);
        end
        mosi[0] = 1'b0;
        wait_clk(H);
        check("cs_high_no_vld", vld_cnt[0] - vld0, 0);
        check("cs_high_no_ack", ack_cnt[0] - ack0, 0);
        check("cs_high_oe_low", oe_cnt[0] - oe0, 0);
        check("cs_high_miso_low", miso_cnt[0] - miso0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
